// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, ROM address, IF/ID register, jump/branch redirect, HALT stop.
// Build option: define FETCH_JUMP_PREDECODE_EN to resolve unconditional jumps in fetch.
//
// state  | meaning
// S_RUN  | fetching normally, PC advances each unstalled cycle
// S_HALT | HALT word fetched; PC frozen, IF/ID fills with bubbles until a branch
module fetch_stage #(
  parameter int unsigned          ADDR_W    = 10,
  parameter int unsigned          INSTR_W   = 10,
  parameter logic [ADDR_W-1:0]    RESET_PC  = '0,
  parameter logic [INSTR_W-1:0]   HALT_WORD = 10'b0010000010
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  input  logic               stall,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  br_target,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  pc_out,
  output logic               valid_out,
  output logic               halted
);

  typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_t;

  state_t               r_state, w_state_nxt;
  logic [ADDR_W-1:0]    r_pc, w_pc_nxt;
  logic [INSTR_W-1:0]   r_instr, w_instr_nxt;
  logic [ADDR_W-1:0]    r_pc_out, w_pc_out_nxt;
  logic                 r_valid, w_valid_nxt;
  logic                 w_jump;
  logic [ADDR_W-1:0]    w_jump_pc;

`ifdef FETCH_JUMP_PREDECODE_EN
  assign w_jump = (rom_data[INSTR_W-1 -: 4] == 4'b1000);
`else
  assign w_jump = 1'b0;
`endif
  assign w_jump_pc = ADDR_W'(rom_data[5:0]);

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_instr_nxt  = r_instr;
    w_pc_out_nxt = r_pc_out;
    w_valid_nxt  = r_valid;
    if (br_taken) begin
      // A resolved branch outranks stall and squashes any speculative HALT.
      w_state_nxt  = S_RUN;
      w_pc_nxt     = br_target;
      w_instr_nxt  = '0;
      w_pc_out_nxt = r_pc;
      w_valid_nxt  = 1'b0;
    end else if (!stall) begin
      if (r_state == S_HALT) begin
        w_instr_nxt  = '0;
        w_pc_out_nxt = r_pc;
        w_valid_nxt  = 1'b0;
      end else if (w_jump) begin
        w_pc_nxt     = w_jump_pc;
        w_instr_nxt  = '0;
        w_pc_out_nxt = r_pc;
        w_valid_nxt  = 1'b0;
      end else begin
        w_instr_nxt  = rom_data;
        w_pc_out_nxt = r_pc;
        w_valid_nxt  = 1'b1;
        if (rom_data == HALT_WORD) begin
          w_state_nxt = S_HALT;
        end else begin
          w_pc_nxt = r_pc + ADDR_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_RUN;
      r_pc     <= RESET_PC;
      r_instr  <= '0;
      r_pc_out <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_instr  <= w_instr_nxt;
      r_pc_out <= w_pc_out_nxt;
      r_valid  <= w_valid_nxt;
    end
  end

  assign rom_addr  = r_pc;
  assign instr_out = r_instr;
  assign pc_out    = r_pc_out;
  assign valid_out = r_valid;
  assign halted    = (r_state == S_HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized traffic against a fetch model.
module tb_fetch_stage;

  localparam logic [9:0] HALT = 10'b0010000010;
`ifdef FETCH_JUMP_PREDECODE_EN
  localparam bit JUMP_EN = 1'b1;
`else
  localparam bit JUMP_EN = 1'b0;
`endif

  logic       clk;
  logic       rst, stall, br_taken;
  logic [9:0] br_target;
  logic [9:0] rom_addr, rom_data, instr_out, pc_out;
  logic       valid_out, halted;

  logic       rst2;
  logic [9:0] wr_rom_addr, wr_instr_out, wr_pc_out;
  logic       wr_valid_out, wr_halted;
  logic [9:0] nop_word;

  logic [9:0] rom [0:1023];

  int n_vec = 0;
  int n_err = 0;

  // reference state
  int         m_pc;
  logic [9:0] m_instr;
  int         m_pc_out;
  logic       m_valid, m_halt, m_pco_known;

  assign rom_data = rom[rom_addr];

  fetch_stage u_dut (
    .clk(clk), .rst(rst), .rom_addr(rom_addr), .rom_data(rom_data),
    .stall(stall), .br_taken(br_taken), .br_target(br_target),
    .instr_out(instr_out), .pc_out(pc_out), .valid_out(valid_out), .halted(halted)
  );

  fetch_stage #(.RESET_PC(10'd1022)) u_wrap (
    .clk(clk), .rst(rst2), .rom_addr(wr_rom_addr), .rom_data(nop_word),
    .stall(1'b0), .br_taken(1'b0), .br_target(10'd0),
    .instr_out(wr_instr_out), .pc_out(wr_pc_out), .valid_out(wr_valid_out), .halted(wr_halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
    end
  endtask

  // One clock: advance the model from the inputs as applied, then compare after the edge.
  task automatic tick();
    logic [9:0] w;
    w = rom[m_pc];
    if (rst) begin
      m_pc = 0; m_instr = '0; m_pc_out = 0; m_valid = 1'b0; m_halt = 1'b0; m_pco_known = 1'b1;
    end else if (br_taken) begin
      m_pc = int'(br_target); m_instr = '0; m_valid = 1'b0; m_halt = 1'b0; m_pco_known = 1'b0;
    end else if (!stall) begin
      if (m_halt) begin
        m_instr = '0; m_valid = 1'b0; m_pco_known = 1'b0;
      end else if (JUMP_EN && w[9:6] == 4'b1000) begin
        m_pc_out = m_pc; m_pco_known = 1'b1;
        m_pc = int'(w[5:0]); m_instr = '0; m_valid = 1'b0;
      end else begin
        m_instr = w; m_pc_out = m_pc; m_valid = 1'b1; m_pco_known = 1'b1;
        if (w == HALT) m_halt = 1'b1;
        else m_pc = (m_pc + 1) % 1024;
      end
    end
    @(posedge clk);
    #1;
    chk_eq("rom_addr", 32'(rom_addr), 32'(m_pc));
    chk_eq("instr_out", 32'(instr_out), 32'(m_instr));
    chk_eq("valid_out", 32'(valid_out), 32'(m_valid));
    chk_eq("halted", 32'(halted), 32'(m_halt));
    if (m_pco_known) chk_eq("pc_out", 32'(pc_out), 32'(m_pc_out));
  endtask

  task automatic set_in(input logic r, input logic s, input logic b, input logic [9:0] t);
    rst = r; stall = s; br_taken = b; br_target = t;
  endtask

  initial begin
    nop_word = 10'd0;
    rst2 = 1'b1;
    for (int i = 0; i < 1024; i++) rom[i] = 10'h001;
    rom[0] = 10'h000; rom[1] = 10'h370; rom[2] = 10'h36D;
    rom[7] = 10'b1000001001;
    rom[32] = HALT;
    m_pc = 0; m_instr = '0; m_pc_out = 0; m_valid = 0; m_halt = 0; m_pco_known = 0;

    // reset and free-run
    set_in(1, 0, 0, 0);
    tick();
    chk_eq("rst_valid", 32'(valid_out), 32'd0);
    chk_eq("rst_pc_out", 32'(pc_out), 32'd0);
    set_in(0, 0, 0, 0);
    tick(); chk_eq("run_pc0", 32'(pc_out), 32'd0); chk_eq("run_i0", 32'(instr_out), 32'h000);
    tick(); chk_eq("run_pc1", 32'(pc_out), 32'd1); chk_eq("run_i1", 32'(instr_out), 32'h370);
    tick(); chk_eq("run_pc2", 32'(pc_out), 32'd2); chk_eq("run_i2", 32'(instr_out), 32'h36D);
    chk_eq("run_v2", 32'(valid_out), 32'd1);

    // jump at 7
    set_in(0, 0, 1, 10'd7); tick();
    set_in(0, 0, 0, 0);     tick();
    if (JUMP_EN) begin
      chk_eq("jmp_bubble_v", 32'(valid_out), 32'd0);
      chk_eq("jmp_bubble_i", 32'(instr_out), 32'd0);
      tick(); chk_eq("jmp_tgt_pc", 32'(pc_out), 32'd9);
    end else begin
      chk_eq("jmp_fwd_pc", 32'(pc_out), 32'd7);
      chk_eq("jmp_fwd_i", 32'(instr_out), 32'h209);
      chk_eq("jmp_fwd_v", 32'(valid_out), 32'd1);
      tick(); chk_eq("jmp_next_pc", 32'(pc_out), 32'd8);
    end

    // stall at pc=10
    set_in(0, 0, 1, 10'd10); tick();
    set_in(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick(); chk_eq("stall_addr", 32'(rom_addr), 32'd10);
    end
    set_in(0, 0, 0, 0); tick();
    chk_eq("stall_resume_pc", 32'(pc_out), 32'd10);
    chk_eq("stall_resume_v", 32'(valid_out), 32'd1);

    // branch during stall at pc=20
    set_in(0, 0, 1, 10'd20); tick();
    set_in(0, 1, 1, 10'd3);  tick();
    chk_eq("brst_v", 32'(valid_out), 32'd0);
    chk_eq("brst_addr", 32'(rom_addr), 32'd3);
    set_in(0, 0, 0, 0); tick();
    chk_eq("brst_pc", 32'(pc_out), 32'd3);

    // halt at 32
    set_in(0, 0, 1, 10'd32); tick();
    set_in(0, 0, 0, 0);      tick();
    chk_eq("halt_pc", 32'(pc_out), 32'd32);
    chk_eq("halt_v", 32'(valid_out), 32'd1);
    chk_eq("halt_flag", 32'(halted), 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_eq("halt_addr", 32'(rom_addr), 32'd32);
      chk_eq("halt_bubble", 32'(valid_out), 32'd0);
    end
    set_in(0, 0, 1, 10'd5); tick();
    chk_eq("unhalt_flag", 32'(halted), 32'd0);
    set_in(0, 0, 0, 0); tick();
    chk_eq("unhalt_pc", 32'(pc_out), 32'd5);
    chk_eq("unhalt_v", 32'(valid_out), 32'd1);

    // PC wrap on the RESET_PC=1022 instance
    set_in(1, 0, 0, 0);
    rst2 = 1'b1; tick();
    chk_eq("wrap_rst_addr", 32'(wr_rom_addr), 32'd1022);
    chk_eq("wrap_rst_v", 32'(wr_valid_out), 32'd0);
    rst2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_eq("wrap_pc", 32'(wr_pc_out), 32'((1022 + i) % 1024));
      chk_eq("wrap_v", 32'(wr_valid_out), 32'd1);
    end
    rst2 = 1'b1; tick();
    chk_eq("wrap_mid_rst_addr", 32'(wr_rom_addr), 32'd1022);
    chk_eq("wrap_mid_rst_pc", 32'(wr_pc_out), 32'd0);
    chk_eq("wrap_mid_rst_i", 32'(wr_instr_out), 32'd0);
    chk_eq("wrap_mid_rst_v", 32'(wr_valid_out), 32'd0);
    chk_eq("wrap_mid_rst_h", 32'(wr_halted), 32'd0);

    // randomized traffic over a random ROM with sprinkled jumps and halts
    for (int i = 0; i < 1024; i++) begin
      int k;
      k = int'($urandom_range(0, 15));
      if (k == 0) rom[i] = HALT;
      else if (k <= 2) rom[i] = {4'b1000, 6'($urandom_range(0, 63))};
      else rom[i] = 10'($urandom_range(0, 1023));
    end
    set_in(1, 0, 0, 0); tick();
    for (int n = 0; n < 3000; n++) begin
      set_in($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 25,
             $urandom_range(0, 99) < 10, 10'($urandom_range(0, 1023)));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
